// File: rtl/win_unchange_pkg.sv
// Shared definitions for the win_unchange window-stability checker.
//   FIRE_* : bit positions inside the fire vector
//   win_state_t : window tracking state (idle / open)
package win_unchange_pkg;

  localparam int FIRE_ASSERT = 0;  // test_expr changed inside a window
  localparam int FIRE_XCHECK = 1;  // test_expr carried X/Z inside a window
  localparam int FIRE_COVER  = 2;  // a window was opened
  localparam int FIRE_WIDTH  = 3;

  typedef enum logic {
    WIN_IDLE = 1'b0,
    WIN_OPEN = 1'b1
  } win_state_t;

endpackage

// File: rtl/win_unchange_core.sv
// Window tracking core: two-state FSM, reference register and comparator.
// Ports:
//   clock       in  rising-edge sampling clock
//   reset       in  asynchronous active-low reset
//   start_event in  window-open request (ignored while a window is open)
//   end_event   in  window-close request (ignored while closed)
//   test_expr   in  monitored value
//   window_open out high while a window is open
//   violation   out combinational: window open and test_expr differs from ref
module win_unchange_core
  import win_unchange_pkg::*;
#(
  parameter int width = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_event,
  input  logic             end_event,
  input  logic [width-1:0] test_expr,
  output logic             window_open,
  output logic             violation
);

  win_state_t       state_reg;
  win_state_t       state_next;
  logic [width-1:0] ref_reg;
  logic [width-1:0] ref_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= WIN_IDLE;
      ref_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ref_reg   <= ref_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ref_next   = ref_reg;
    violation  = 1'b0;
    case (state_reg)
      WIN_IDLE: begin
        // end_event on the opening edge is deliberately not honoured.
        if (start_event) begin
          state_next = WIN_OPEN;
          ref_next   = test_expr;
        end
      end
      WIN_OPEN: begin
        // The closing edge is still compared; ref is never re-captured,
        // so a persisting change keeps flagging on every edge.
        violation = (test_expr != ref_reg);
        if (end_event) begin
          state_next = WIN_IDLE;
        end
      end
      default: begin
        state_next = WIN_IDLE;
      end
    endcase
  end

  assign window_open = (state_reg == WIN_OPEN);

endmodule

// File: rtl/win_unchange_checker.sv
// win_unchange_checker: passive observer checking that test_expr holds the
// value captured at start_event until (and including) the end_event edge.
// Ports:
//   clock       in  rising-edge sampling clock
//   reset       in  asynchronous active-low reset
//   enable      in  gates reporting only; window tracking keeps running
//   start_event in  window-open request
//   test_expr   in  [width] value that must stay unchanged inside a window
//   end_event   in  window-close request
//   fire        out [3] registered one-cycle pulses:
//                   [0] change detected, [1] X/Z seen, [2] window opened
// Optional build macro WIN_UNCHANGE_COVER_EN enables fire[2] and a 32-bit
// saturating window-open counter (cover_count); otherwise fire[2] is 0.
module win_unchange_checker
  import win_unchange_pkg::*;
#(
  parameter int width = 1,
  parameter     msg   = "VIOLATION"
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start_event,
  input  logic [width-1:0]      test_expr,
  input  logic                  end_event,
  output logic [FIRE_WIDTH-1:0] fire
);

  logic                  window_open;
  logic                  violation;
  logic                  xcheck_now;
  logic                  cover_now;
  logic [FIRE_WIDTH-1:0] fire_next;
  logic [FIRE_WIDTH-1:0] fire_reg;

  win_unchange_core #(
    .width(width)
  ) u_core (
    .clock       (clock),
    .reset       (reset),
    .start_event (start_event),
    .end_event   (end_event),
    .test_expr   (test_expr),
    .window_open (window_open),
    .violation   (violation)
  );

  // X/Z detection only has meaning in a four-state simulator.
`ifndef SYNTHESIS
  assign xcheck_now = window_open && $isunknown(test_expr);
`else
  assign xcheck_now = 1'b0;
`endif

`ifdef WIN_UNCHANGE_COVER_EN
  logic        open_edge;
  logic [31:0] cover_count;

  assign open_edge = !window_open && start_event;
  assign cover_now = open_edge;

  // Counts every opened window, independent of enable; sticks at all-ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cover_count <= '0;
    end else if (open_edge && (cover_count != '1)) begin
      cover_count <= cover_count + 32'd1;
    end
  end
`else
  assign cover_now = 1'b0;
`endif

  always_comb begin
    fire_next = '0;
    if (enable) begin
      fire_next[FIRE_ASSERT] = violation;
      fire_next[FIRE_XCHECK] = xcheck_now;
      fire_next[FIRE_COVER]  = cover_now;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fire_reg <= '0;
    end else begin
      fire_reg <= fire_next;
    end
  end

  assign fire = fire_reg;

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset && fire_next[FIRE_ASSERT]) begin
      $display("%s: win_unchange test_expr changed at time %0t", msg, $time);
    end
  end
`endif

endmodule

// File: tb/tb_win_unchange_checker.sv
// Self-checking bench for win_unchange_checker (width=4): a directed vector
// table, a hand-written asynchronous-reset sequence and a randomized phase
// checked against a behavioural model.
module tb_win_unchange_checker;

`ifdef WIN_UNCHANGE_COVER_EN
  localparam bit COV_ON = 1'b1;
`else
  localparam bit COV_ON = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       enable;
  logic       start_event;
  logic [3:0] test_expr;
  logic       end_event;
  logic [2:0] fire;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural model: captured value of the open window, or -1 when closed.
  int mdl_win = -1;
  int mdl_count = 0;

  win_unchange_checker #(
    .width(4),
    .msg  ("VIOLATION")
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .start_event (start_event),
    .test_expr   (test_expr),
    .end_event   (end_event),
    .fire        (fire)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       en;
    logic       st;
    logic       ev;
    logic [3:0] tx;
    logic       f0;  // expected fire[0] after this edge
    logic       op;  // this edge opens a window
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: fire=%b expected %b", name, got, exp);
    end else begin
      $display("[TB] ok %s: fire=%b", name, got);
    end
  endtask

  task automatic model_step(input logic rst, input logic en, input logic s, input logic e,
                            input logic [3:0] t, output logic [2:0] exp);
    exp = '0;
    if (!rst) begin
      mdl_win   = -1;
      mdl_count = 0;
    end else if (mdl_win >= 0) begin
      if (en && (int'(t) != mdl_win)) exp[0] = 1'b1;
      if (e) mdl_win = -1;
    end else if (s) begin
      exp[2]  = COV_ON && en;
      mdl_win = int'(t);
      mdl_count++;
    end
  endtask

  // Drive at the falling edge, let one rising edge act, sample 1 ns later.
  task automatic apply(input logic rst, input logic en, input logic s, input logic e,
                       input logic [3:0] t);
    @(negedge clock);
    reset       = rst;
    enable      = en;
    start_event = s;
    end_event   = e;
    test_expr   = t;
    @(posedge clock);
    #1;
  endtask

  task automatic run_model(input string name, input logic rst, input logic en, input logic s,
                           input logic e, input logic [3:0] t);
    logic [2:0] exp;
    model_step(rst, en, s, e, t, exp);
    apply(rst, en, s, e, t);
    check(name, fire, exp);
  endtask

  initial begin
    logic [2:0] exp;
    logic [2:0] dummy;
    logic [3:0] tx;

    reset = 1'b0; enable = 1'b0; start_event = 1'b0; end_event = 1'b0; test_expr = 4'h0;
    #1;
    check("reset_state", fire, 3'b000);

    //                rst  en   st   ev   tx     f0   op
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0,4'h0, 1'b0,1'b0}); // reset hold
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,4'h0, 1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,4'h0, 1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'h8, 1'b0,1'b1}); // pass window opens
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'h8, 1'b0,1'b0}); // start ignored
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,4'h8, 1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,4'h8, 1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,4'h8, 1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b1,4'h8, 1'b0,1'b0}); // close
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,4'h3, 1'b0,1'b0}); // change after close
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'h8, 1'b0,1'b1}); // change inside window
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,4'h8, 1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,4'h9, 1'b1,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,4'h9, 1'b1,1'b0}); // repeats
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,4'h8, 1'b0,1'b0}); // ref kept
    vecs.push_back('{1'b1,1'b1,1'b0,1'b1,4'h3, 1'b1,1'b0}); // change on end edge
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,4'h5, 1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b1,1'b1,4'h2, 1'b0,1'b1}); // start+end while closed
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,4'h2, 1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,4'h4, 1'b1,1'b0}); // still open
    vecs.push_back('{1'b1,1'b1,1'b1,1'b1,4'h2, 1'b0,1'b0}); // start+end while open
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,4'h7, 1'b0,1'b0}); // no reopen
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'h6, 1'b0,1'b1}); // change coincident with start
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,4'h6, 1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b1,4'h6, 1'b0,1'b0});
    vecs.push_back('{1'b1,1'b0,1'b1,1'b0,4'h8, 1'b0,1'b1}); // enable low
    vecs.push_back('{1'b1,1'b0,1'b0,1'b0,4'h9, 1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,4'h9, 1'b1,1'b0}); // enable back
    vecs.push_back('{1'b1,1'b1,1'b0,1'b1,4'h8, 1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'h1, 1'b0,1'b1}); // reset mid-window
    vecs.push_back('{1'b0,1'b1,1'b0,1'b0,4'h1, 1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,4'h5, 1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,4'h6, 1'b0,1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      exp = {COV_ON & vecs[i].op & vecs[i].en & vecs[i].rst, 1'b0, vecs[i].f0};
      model_step(vecs[i].rst, vecs[i].en, vecs[i].st, vecs[i].ev, vecs[i].tx, dummy);
      apply(vecs[i].rst, vecs[i].en, vecs[i].st, vecs[i].ev, vecs[i].tx);
      check($sformatf("vec%0d", i), fire, exp);
    end

    // Asynchronous reset between edges clears a pending fire immediately.
    run_model("async_open", 1'b1, 1'b1, 1'b1, 1'b0, 4'hA);
    run_model("async_viol", 1'b1, 1'b1, 1'b0, 1'b0, 4'hB);
    #2;
    reset = 1'b0;
    model_step(1'b0, 1'b1, 1'b0, 1'b0, 4'hB, dummy);
    #1;
    check("async_reset_clear", fire, 3'b000);
    run_model("async_hold", 1'b0, 1'b1, 1'b0, 1'b0, 4'hB);
    run_model("async_release", 1'b1, 1'b1, 1'b0, 1'b0, 4'hC);

    // Randomized phase against the behavioural model.
    tx = 4'h0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) == 0) tx = 4'($urandom);
      run_model($sformatf("rand%0d", n),
                ($urandom_range(59) != 0),
                ($urandom_range(7) != 0),
                ($urandom_range(4) == 0),
                ($urandom_range(5) == 0),
                tx);
    end

`ifdef WIN_UNCHANGE_COVER_EN
    tests_run++;
    if (dut.cover_count !== 32'(mdl_count)) begin
      tests_failed++;
      $display("FAIL cover_count: got %0d expected %0d", dut.cover_count, mdl_count);
    end else begin
      $display("[TB] ok cover_count: %0d", dut.cover_count);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
